// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

   localparam int INST_W = 32;

   localparam logic [INST_W-1:0] NOP_INST         = 32'h0000_0013;
   localparam logic [INST_W-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

   // Fetch FSM states: issue request, wait for read data, hold for decode
   typedef enum logic [1:0] {
      REQ  = 2'b00,
      WAIT = 2'b01,
      HOLD = 2'b10
   } fetch_state_e;

endpackage

// File: rtl/fetch_pc_reg.sv
// Program counter register for the fetch stage. A redirect load takes
// precedence over the sequential +4 increment, which wraps modulo 2^32.
module fetch_pc_reg
   import fetch_pkg::*;
#(
   parameter logic [INST_W-1:0] RESET_PC = DEFAULT_RESET_PC
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load_redirect,
   input  logic              load_incr,
   input  logic [INST_W-1:0] target,
   output logic [INST_W-1:0] pc_o
);

   logic [INST_W-1:0] pc_q;
   logic [INST_W-1:0] pc_d;

   // Choose the next program counter: redirect target, next word, or hold
   always_comb begin
      pc_d = pc_q;
      if (load_redirect) begin
         pc_d = target;
      end else if (load_incr) begin
         pc_d = pc_q + 32'd4;
      end
   end

   // Program counter register, reset to the boot address
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc_q <= RESET_PC;
      end else begin
         pc_q <= pc_d;
      end
   end

   assign pc_o = pc_q;

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: single-outstanding req/gnt/rvalid fetch with
// redirect handling and stale-response discard.
// Optional macro FETCH_MISALIGN_CHECK_EN: misaligned redirect targets are
// refused and flagged on misalign; otherwise low target bits are cleared.
module instr_fetch
   import fetch_pkg::*;
#(
   parameter logic [INST_W-1:0] RESET_PC = DEFAULT_RESET_PC
) (
   input  logic              clk,
   input  logic              rst,
   output logic              imem_req,
   output logic [INST_W-1:0] imem_addr,
   input  logic              imem_gnt,
   input  logic              imem_rvalid,
   input  logic [INST_W-1:0] imem_rdata,
   input  logic              redirect,
   input  logic [INST_W-1:0] redirect_pc,
   input  logic              stall,
   output logic [INST_W-1:0] inst,
   output logic [INST_W-1:0] pc,
   output logic              inst_valid,
   output logic              misalign
);

   fetch_state_e      state_q;
   fetch_state_e      state_d;
   logic              discard_q;
   logic              discard_d;
   logic [INST_W-1:0] inst_q;
   logic [INST_W-1:0] inst_d;
   logic              loadRedirect;
   logic              loadIncr;
   logic              redirTake;
   logic [INST_W-1:0] targetPc;

`ifdef FETCH_MISALIGN_CHECK_EN
   logic misalignHit;
   logic misalign_q;

   assign redirTake   = redirect && (redirect_pc[1:0] == 2'b00);
   assign misalignHit = redirect && (redirect_pc[1:0] != 2'b00);
   assign targetPc    = redirect_pc;

   // One-cycle registered flag for a refused misaligned redirect
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         misalign_q <= 1'b0;
      end else begin
         misalign_q <= misalignHit;
      end
   end

   assign misalign = misalign_q;
`else
   assign redirTake = redirect;
   assign targetPc  = redirect_pc & 32'hFFFF_FFFC;
   assign misalign  = 1'b0;
`endif

   fetch_pc_reg #(
      .RESET_PC(RESET_PC)
   ) u_pc_reg (
      .clk          (clk),
      .rst          (rst),
      .load_redirect(loadRedirect),
      .load_incr    (loadIncr),
      .target       (targetPc),
      .pc_o         (pc)
   );

   // Next-state logic: a redirect always wins over consume, and marks any
   // response still in flight as stale so it is dropped on arrival
   always_comb begin
      state_d      = state_q;
      discard_d    = discard_q;
      inst_d       = inst_q;
      loadRedirect = 1'b0;
      loadIncr     = 1'b0;
      case (state_q)
         REQ: begin
            if (redirTake) begin
               loadRedirect = 1'b1;
               if (imem_gnt) begin
                  state_d   = WAIT;
                  discard_d = 1'b1;
               end
            end else if (imem_gnt) begin
               state_d   = WAIT;
               discard_d = 1'b0;
            end
         end
         WAIT: begin
            if (imem_rvalid) begin
               if (discard_q || redirTake) begin
                  discard_d    = 1'b0;
                  state_d      = REQ;
                  loadRedirect = redirTake;
               end else begin
                  inst_d  = imem_rdata;
                  state_d = HOLD;
               end
            end else if (redirTake) begin
               loadRedirect = 1'b1;
               discard_d    = 1'b1;
            end
         end
         HOLD: begin
            if (redirTake) begin
               loadRedirect = 1'b1;
               state_d      = REQ;
            end else if (!stall) begin
               loadIncr = 1'b1;
               state_d  = REQ;
            end
         end
         default: begin
            state_d   = REQ;
            discard_d = 1'b0;
         end
      endcase
   end

   // State, discard flag and instruction latch registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= REQ;
         discard_q <= 1'b0;
         inst_q    <= NOP_INST;
      end else begin
         state_q   <= state_d;
         discard_q <= discard_d;
         inst_q    <= inst_d;
      end
   end

   // Outputs depend on registered state only; request is held off in reset
   assign imem_req   = (state_q == REQ) && !rst;
   assign imem_addr  = pc;
   assign inst_valid = (state_q == HOLD);
   assign inst       = inst_q;

endmodule
